// File: rtl/rr_grant_arbiter_if.sv
// ----------------------------------------------------------------------------
// rr_grant_arbiter_if
//   Request/grant bundle between a set of bus masters and rr_grant_arbiter.
//
//   Handshake: each requester raises req[i] and keeps it high for as long as
//   it wants to own the shared resource. The arbiter answers with a
//   registered one-hot gnt. The requester owns the resource in every cycle
//   where gnt[i]=1. It gives up ownership by dropping req[i]. gnt_id is
//   meaningful only while busy=1.
//
//   Signals:
//     req       N_REQ  per-requester request/hold level   (master -> arbiter)
//     gnt       N_REQ  registered one-hot grant            (arbiter -> master)
//     gnt_id    ID_W   index of current owner              (arbiter -> master)
//     busy      1      1 while any gnt bit is set          (arbiter -> master)
//     dbg_state 1      arbiter FSM state, 0=IDLE 1=GRANT   (arbiter -> master)
// ----------------------------------------------------------------------------
interface rr_grant_arbiter_if #(
  parameter int N_REQ = 4
);
  localparam int ID_W = $clog2(N_REQ);

  logic [N_REQ-1:0] req;
  logic [N_REQ-1:0] gnt;
  logic [ID_W-1:0]  gnt_id;
  logic             busy;
  logic             dbg_state;

  modport master (output req, input gnt, gnt_id, busy, dbg_state);
  modport slave  (input req, output gnt, gnt_id, busy, dbg_state);
endinterface

// File: rtl/rr_grant_arbiter.sv
// ----------------------------------------------------------------------------
// rr_grant_arbiter
//   N-requester round-robin grant arbiter. An owner keeps its grant until it
//   drops req. Handover to the next requester happens on the same edge as the
//   release, so gnt never shows a zero cycle between two owners.
//
//   Optional feature (macro RR_HOLD_LIMIT_EN): this macro limits how long one
//   owner can hold the grant. When the owner has held the grant for HOLD_MAX
//   cycles and another requester is waiting, the arbiter hands the grant to
//   the next requester. The preempted owner keeps its req high and competes
//   again later in round-robin order.
//
//   Parameters:
//     N_REQ     number of requesters, 2..16
//     HOLD_MAX  tenure limit in cycles, 1..255 (only with RR_HOLD_LIMIT_EN)
//
//   Ports:
//     clock  single clock, all logic on posedge
//     reset  synchronous, active-high
//     bus    rr_grant_arbiter_if.slave (req in; gnt, gnt_id, busy,
//            dbg_state out)
// ----------------------------------------------------------------------------
module rr_grant_arbiter #(
  parameter int N_REQ    = 4,
  parameter int HOLD_MAX = 8
) (
  input  logic           clock,
  input  logic           reset,
  rr_grant_arbiter_if.slave bus
);

  localparam int ID_W = $clog2(N_REQ);
  localparam logic [N_REQ-1:0] ONE = N_REQ'(1);

  if (N_REQ < 2 || N_REQ > 16 || HOLD_MAX < 1 || HOLD_MAX > 255) begin : g_bad_params
    $error("rr_grant_arbiter: N_REQ must be 2..16 and HOLD_MAX 1..255");
  end

  typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;

  state_t           state;
  logic [ID_W-1:0]  ptr;
  logic [ID_W-1:0]  owner;
  logic [N_REQ-1:0] gnt_r;
  logic             busy_r;

  logic [N_REQ-1:0] cand;
  logic             pick_valid;
  logic [ID_W-1:0]  pick_id;
  logic [ID_W-1:0]  ptr_next;
  logic             keep;
  logic             new_grant;

  // Round-robin pick. The scan starts at ptr and wraps around. The current
  // owner is always masked out: on a release its req is already 0, and on a
  // forced handover it must not win again.
  always_comb begin
    int idx;
    idx        = 0;
    cand       = bus.req;
    if (state == GRANT) cand[owner] = 1'b0;
    pick_valid = 1'b0;
    pick_id    = '0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = int'(ptr) + k;
      if (idx >= N_REQ) idx = idx - N_REQ;
      if (!pick_valid && cand[idx]) begin
        pick_valid = 1'b1;
        pick_id    = ID_W'(idx);
      end
    end
  end

  assign ptr_next = (pick_id == ID_W'(N_REQ - 1)) ? '0 : pick_id + 1'b1;

`ifdef RR_HOLD_LIMIT_EN
  // tenure counts the grant cycles the owner has already completed. The
  // owner is therefore preempted after exactly HOLD_MAX cycles of grant.
  logic [7:0] tenure;
  logic       limit_hit;

  assign limit_hit = (tenure >= 8'(HOLD_MAX - 1)) && pick_valid;
  assign keep      = (state == GRANT) && bus.req[owner] && !limit_hit;

  always_ff @(posedge clock) begin
    if (reset) begin
      tenure <= '0;
    end else if (!keep) begin
      tenure <= '0;
    end else if (tenure < 8'(HOLD_MAX)) begin
      tenure <= tenure + 8'd1;
    end
  end
`else
  assign keep = (state == GRANT) && bus.req[owner];
`endif

  assign new_grant = !keep && pick_valid;

  always_ff @(posedge clock) begin
    if (reset) begin
      state  <= IDLE;
      ptr    <= '0;
      owner  <= '0;
      gnt_r  <= '0;
      busy_r <= 1'b0;
    end else if (new_grant) begin
      state  <= GRANT;
      owner  <= pick_id;
      gnt_r  <= ONE << pick_id;
      busy_r <= 1'b1;
      ptr    <= ptr_next;
    end else if (!keep) begin
      // No owner and nobody waiting. owner is kept as the last gnt_id.
      state  <= IDLE;
      gnt_r  <= '0;
      busy_r <= 1'b0;
    end
  end

  assign bus.gnt       = gnt_r;
  assign bus.gnt_id    = owner;
  assign bus.busy      = busy_r;
  assign bus.dbg_state = (state == GRANT);

endmodule
